// File: rtl/timer_pkg.sv
// Shared types and constants for the M:SS countdown timer and its helpers.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector; RISING selects rising vs falling edge.
// The reset value sets the assumed idle level so no edge appears after reset.
module edge_detect #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   RISING  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic evt
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else begin
            q_reg <= d;
        end
    end

    assign evt = RISING ? (~q_reg & d) : (q_reg & ~d);

endmodule

// File: rtl/timer_mmss.sv
// M:SS countdown timer fed by the keypad encoder; keys shift digits in, 1 Hz ticks count down.
// Optional end-of-cook beep is built only when TIMER_BEEP_EN is defined.
module timer_mmss
    import timer_pkg::*;
#(
    parameter bcd_t SEC_TENS_WRAP = 4'd5,
    parameter bcd_t SEC_ONES_WRAP = BCD_NINE
`ifdef TIMER_BEEP_EN
    ,
    parameter int   BEEP_TICKS    = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_in,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       enablen,
    input  logic       clear,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done,
    output logic       beep
);

    logic   key_evt;
    logic   tick_evt;

    state_t state_reg, state_next;
    bcd_t   mins_reg, mins_next;
    bcd_t   sec_tens_reg, sec_tens_next;
    bcd_t   sec_ones_reg, sec_ones_next;
    logic   done_reg, done_next;
    bcd_t   mins_dec, sec_tens_dec, sec_ones_dec;

    edge_detect #(.RST_VAL(1'b1), .RISING(1'b0)) u_key_edge (
        .clk (clk),
        .rst (rst),
        .d   (loadn),
        .evt (key_evt)
    );

    edge_detect #(.RST_VAL(1'b0), .RISING(1'b1)) u_tick_edge (
        .clk (clk),
        .rst (rst),
        .d   (pgt_1hz),
        .evt (tick_evt)
    );

    assign zero = ((mins_reg | sec_tens_reg | sec_ones_reg) == BCD_ZERO);

    // One-second borrow chain; sec_tens above the wrap value simply counts down.
    always_comb begin
        mins_dec     = mins_reg;
        sec_tens_dec = sec_tens_reg;
        sec_ones_dec = sec_ones_reg;
        if (sec_ones_reg != BCD_ZERO) begin
            sec_ones_dec = sec_ones_reg - 4'd1;
        end else begin
            sec_ones_dec = SEC_ONES_WRAP;
            if (sec_tens_reg != BCD_ZERO) begin
                sec_tens_dec = sec_tens_reg - 4'd1;
            end else begin
                sec_tens_dec = SEC_TENS_WRAP;
                mins_dec     = mins_reg - 4'd1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        mins_next     = mins_reg;
        sec_tens_next = sec_tens_reg;
        sec_ones_next = sec_ones_reg;
        done_next     = 1'b0;

        if (clear) begin
            state_next    = IDLE;
            mins_next     = BCD_ZERO;
            sec_tens_next = BCD_ZERO;
            sec_ones_next = BCD_ZERO;
        end else begin
            case (state_reg)
                IDLE, SET, PAUSE: begin
                    if (enablen) begin
                        if (key_evt) begin
                            mins_next     = sec_tens_reg;
                            sec_tens_next = sec_ones_reg;
                            sec_ones_next = bcd_in;
                            if (state_reg != PAUSE) begin
                                state_next = SET;
                            end
                        end
                    end else if ((state_reg != IDLE) && !zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (enablen) begin
                        state_next = PAUSE;
                    end else if (tick_evt) begin
                        if (zero) begin
                            state_next = IDLE;
                        end else begin
                            mins_next     = mins_dec;
                            sec_tens_next = sec_tens_dec;
                            sec_ones_next = sec_ones_dec;
                            if ((mins_dec | sec_tens_dec | sec_ones_dec) == BCD_ZERO) begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mins_reg     <= BCD_ZERO;
            sec_tens_reg <= BCD_ZERO;
            sec_ones_reg <= BCD_ZERO;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mins_reg     <= mins_next;
            sec_tens_reg <= sec_tens_next;
            sec_ones_reg <= sec_ones_next;
            done_reg     <= done_next;
        end
    end

    assign mins     = mins_reg;
    assign sec_tens = sec_tens_reg;
    assign sec_ones = sec_ones_reg;
    assign done     = done_reg;

`ifdef TIMER_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);

    logic [BEEP_W-1:0] beep_cnt_reg;

    // Beep arms on the clk after done; the tick that produced done is not counted.
    always_ff @(posedge clk) begin
        if (rst || clear || key_evt) begin
            beep_cnt_reg <= '0;
        end else if (done_reg) begin
            beep_cnt_reg <= BEEP_W'(BEEP_TICKS);
        end else if ((beep_cnt_reg != '0) && tick_evt) begin
            beep_cnt_reg <= beep_cnt_reg - 1'b1;
        end
    end

    assign beep = (beep_cnt_reg != '0);
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_timer_mmss.sv
// Self-checking bench for timer_mmss: directed scenarios plus a randomized run
// against a seconds-arithmetic model. Beep checks activate with TIMER_BEEP_EN.
module tb_timer_mmss;

    localparam int BEEP_TICKS = 3;
    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd_in = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1hz = 1'b0;
    logic       enablen = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       zero, done, beep;

    int checks = 0;
    int errors = 0;

    // Model: count as integer mins*100 + seconds field, plus abstract state.
    int mv = 0;
    int ms = M_IDLE;
    bit men = 1'b1;
    int mbeep = 0;
    bit mdone = 1'b0;

    timer_mmss dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .loadn    (loadn),
        .pgt_1hz  (pgt_1hz),
        .enablen  (enablen),
        .clear    (clear),
        .mins     (mins),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .done     (done),
        .beep     (beep)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_digits();
        logic [3:0] m, t, o;
        m = 4'(mv / 100);
        t = 4'((mv / 10) % 10);
        o = 4'(mv % 10);
        return {m, t, o};
    endfunction

    function automatic logic exp_beep();
`ifdef TIMER_BEEP_EN
        return mbeep > 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_key(input int d);
        if (men && ms != M_RUN) begin
            mv = (mv * 10 + d) % 1000;
            if (ms != M_PAUSE) ms = M_SET;
        end
        mbeep = 0;
    endfunction

    function automatic void model_tick();
        mdone = 1'b0;
        if (mbeep > 0) mbeep--;
        if (ms == M_RUN) begin
            mv = (mv % 100 == 0) ? mv - 41 : mv - 1;
            if (mv == 0) begin
                mdone = 1'b1;
                ms = M_IDLE;
                mbeep = BEEP_TICKS;
            end
        end
    endfunction

    function automatic void model_en(input bit v);
        men = v;
        if (!v && (ms == M_SET || ms == M_PAUSE) && mv != 0) ms = M_RUN;
        if (v && ms == M_RUN) ms = M_PAUSE;
    endfunction

    function automatic void model_clear();
        mv = 0;
        ms = M_IDLE;
        mbeep = 0;
    endfunction

    task automatic do_key(input int d, input int hold);
        @(negedge clk);
        bcd_in = 4'(d);
        loadn = 1'b0;
        repeat (hold) @(negedge clk);
        loadn = 1'b1;
        model_key(d);
    endtask

    // Returns done one and two negedges after the tick edge, and beep at the second.
    task automatic do_tick(output logic d0, output logic d1, output logic b1);
        @(negedge clk);
        pgt_1hz = 1'b1;
        @(negedge clk);
        pgt_1hz = 1'b0;
        d0 = done;
        model_tick();
        @(negedge clk);
        d1 = done;
        b1 = beep;
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        enablen = v;
        @(negedge clk);
        model_en(v);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({mins, sec_tens, sec_ones, zero, done, beep} !== {12'h000, 3'b100}) begin
            errors++;
            $display("FAIL reset: got digits=%h zero=%b done=%b beep=%b, want 000 1 0 0",
                     {mins, sec_tens, sec_ones}, zero, done, beep);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mins, sec_tens, sec_ones, zero} !== {12'h000, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: got digits=%h zero=%b, want 000 1",
                     {mins, sec_tens, sec_ones}, zero);
        end
        $display("reset: digits=%h zero=%b", {mins, sec_tens, sec_ones}, zero);
    endtask

    task automatic test_load();
        int keys[3] = '{1, 3, 0};
        logic [11:0] want[3] = '{12'h001, 12'h013, 12'h130};
        for (int i = 0; i < 3; i++) begin
            do_key(keys[i], 1);
            checks++;
            if ({mins, sec_tens, sec_ones} !== want[i] || zero !== 1'b0
                || {mins, sec_tens, sec_ones} !== exp_digits()) begin
                errors++;
                $display("FAIL load_%0d: got %h zero=%b, want %h zero=0",
                         i, {mins, sec_tens, sec_ones}, zero, want[i]);
            end
            $display("key %0d: digits=%h", keys[i], {mins, sec_tens, sec_ones});
        end
    endtask

    task automatic test_run();
        logic d0, d1, b1;
        logic [11:0] want[3] = '{12'h129, 12'h128, 12'h127};
        set_en(1'b0);
        for (int i = 0; i < 3; i++) begin
            do_tick(d0, d1, b1);
            checks++;
            if ({mins, sec_tens, sec_ones} !== want[i] || d0 !== 1'b0) begin
                errors++;
                $display("FAIL run_tick_%0d: got %h done=%b, want %h done=0",
                         i, {mins, sec_tens, sec_ones}, d0, want[i]);
            end
            $display("tick: digits=%h", {mins, sec_tens, sec_ones});
        end
        do_key(4, 1);
        do_key(7, 2);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h127) begin
            errors++;
            $display("FAIL run_key_ignored: got %h, want 127", {mins, sec_tens, sec_ones});
        end
        $display("keys while running: digits=%h", {mins, sec_tens, sec_ones});
        set_en(1'b1);
        do_clear();
    endtask

    task automatic test_done();
        logic d0, d1, b1;
        do_key(0, 1);
        do_key(0, 1);
        do_key(2, 3);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h002) begin
            errors++;
            $display("FAIL done_load: got %h, want 002 (held key must shift once)",
                     {mins, sec_tens, sec_ones});
        end
        set_en(1'b0);
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h001 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL done_tick1: got %h done=%b, want 001 done=0",
                     {mins, sec_tens, sec_ones}, d0);
        end
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || d0 !== 1'b1 || d1 !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %h done=%b,%b zero=%b, want 000 done=1,0 zero=1",
                     {mins, sec_tens, sec_ones}, d0, d1, zero);
        end
        checks++;
        if (b1 !== exp_beep()) begin
            errors++;
            $display("FAIL done_beep_start: got beep=%b, want %b", b1, exp_beep());
        end
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || d0 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL done_extra_tick: got %h done=%b, want 000 done=0",
                     {mins, sec_tens, sec_ones}, d0);
        end
        $display("countdown to zero: digits=%h zero=%b", {mins, sec_tens, sec_ones}, zero);
        set_en(1'b1);
        do_clear();
    endtask

    task automatic test_pause();
        logic d0, d1, b1;
        do_key(1, 1);
        do_key(0, 1);
        do_key(0, 1);
        set_en(1'b0);
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h059) begin
            errors++;
            $display("FAIL pause_borrow: got %h, want 059", {mins, sec_tens, sec_ones});
        end
        set_en(1'b1);
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h059) begin
            errors++;
            $display("FAIL pause_hold: got %h, want 059", {mins, sec_tens, sec_ones});
        end
        do_key(5, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h595) begin
            errors++;
            $display("FAIL pause_shift: got %h, want 595", {mins, sec_tens, sec_ones});
        end
        set_en(1'b0);
        do_tick(d0, d1, b1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h594) begin
            errors++;
            $display("FAIL pause_resume: got %h, want 594", {mins, sec_tens, sec_ones});
        end
        $display("pause/resume: digits=%h", {mins, sec_tens, sec_ones});
        set_en(1'b1);
        do_clear();
    endtask

    task automatic test_clear_tick();
        logic d0, d1;
        do_key(1, 1);
        do_key(0, 1);
        set_en(1'b0);
        @(negedge clk);
        pgt_1hz = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        pgt_1hz = 1'b0;
        clear = 1'b0;
        d0 = done;
        model_clear();
        @(negedge clk);
        d1 = done;
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || zero !== 1'b1 || d0 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_tick: got %h zero=%b done=%b,%b, want 000 1 0,0",
                     {mins, sec_tens, sec_ones}, zero, d0, d1);
        end
        $display("clear with tick: digits=%h", {mins, sec_tens, sec_ones});
        set_en(1'b1);
    endtask

    task automatic test_rst_mid_run();
        logic d0, d1, b1;
        do_key(3, 1);
        do_key(4, 1);
        set_en(1'b0);
        do_tick(d0, d1, b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if ({mins, sec_tens, sec_ones, zero, done, beep} !== {12'h000, 3'b100}) begin
            errors++;
            $display("FAIL rst_mid_run: got %h zero=%b done=%b beep=%b, want 000 1 0 0",
                     {mins, sec_tens, sec_ones}, zero, done, beep);
        end
        $display("reset mid run: digits=%h", {mins, sec_tens, sec_ones});
        set_en(1'b1);
    endtask

    task automatic test_beep();
        logic d0, d1, b1;
        for (int rep = 0; rep < 2; rep++) begin
            do_clear();
            do_key(1, 1);
            set_en(1'b0);
            do_tick(d0, d1, b1);
            checks++;
            if (d0 !== 1'b1 || b1 !== exp_beep()) begin
                errors++;
                $display("FAIL beep_start_%0d: got done=%b beep=%b, want 1 %b", rep, d0, b1, exp_beep());
            end
            if (rep == 0) begin
                for (int t = 0; t < BEEP_TICKS + 1; t++) begin
                    do_tick(d0, d1, b1);
                    checks++;
                    if (b1 !== exp_beep()) begin
                        errors++;
                        $display("FAIL beep_tick_%0d: got beep=%b, want %b", t, b1, exp_beep());
                    end
                    $display("beep tick %0d: beep=%b", t, b1);
                end
            end else begin
                do_key(6, 1);
                checks++;
                if (beep !== 1'b0 || {mins, sec_tens, sec_ones} !== exp_digits()) begin
                    errors++;
                    $display("FAIL beep_key_stop: got beep=%b digits=%h, want 0 %h",
                             beep, {mins, sec_tens, sec_ones}, exp_digits());
                end
                $display("key during beep: beep=%b", beep);
            end
            set_en(1'b1);
        end
        do_clear();
    endtask

    task automatic test_random();
        logic d0, d1, b1;
        int op;
        do_clear();
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            d0 = mdone;
            if (op <= 3) begin
                do_key($urandom_range(0, 9), $urandom_range(1, 3));
            end else if (op == 7) begin
                set_en(1'b0);
            end else if (op == 8) begin
                set_en(1'b1);
            end else if (op == 9 && $urandom_range(0, 3) == 0) begin
                do_clear();
            end else begin
                do_tick(d0, d1, b1);
                checks++;
                if (d0 !== mdone || d1 !== 1'b0 || b1 !== exp_beep()) begin
                    errors++;
                    $display("FAIL rand_tick_%0d: got done=%b,%b beep=%b, want %b,0 %b",
                             i, d0, d1, b1, mdone, exp_beep());
                end
            end
            checks++;
            if ({mins, sec_tens, sec_ones} !== exp_digits() || zero !== (mv == 0)
                || beep !== exp_beep()) begin
                errors++;
                $display("FAIL rand_%0d: got %h zero=%b beep=%b, want %h zero=%b beep=%b",
                         i, {mins, sec_tens, sec_ones}, zero, beep, exp_digits(), (mv == 0), exp_beep());
            end
            $display("rand %0d op=%0d: digits=%h zero=%b", i, op, {mins, sec_tens, sec_ones}, zero);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_done();
        test_pause();
        test_clear_tick();
        test_rst_mid_run();
`ifdef TIMER_BEEP_EN
        test_beep();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_mmss.md
Name: timer_mmss

Overview:
- Countdown timer stage directly downstream of the keypad encoder.
- Captures BCD digits from the encoder's bcd_output and loadn, shifting them into an M:SS register.
- Decrements the register once per rising edge of the encoder's pgt_1hz while cooking is enabled.
- Presents digits to the display decoders and flags zero/done to the microwave controller.

Parameters:
- SEC_TENS_WRAP, 5: value loaded into seconds-tens on a borrow from 0.
- SEC_ONES_WRAP, 9: value loaded into seconds-ones on a borrow from 0.
- BEEP_TICKS, 3: number of pgt_1hz ticks beep stays high (only with TIMER_BEEP_EN).

Ports:
- clk  input  1  system clock, same clock as the encoder.
- rst  input  1  synchronous active-high reset.
- bcd_in  input  4  digit from the encoder; valid while loadn=0.
- loadn  input  1  active-low key-valid from the encoder.
- pgt_1hz  input  1  1 Hz tick level from the encoder; sampled in the clk domain.
- enablen  input  1  active-low run enable; the same net drives the encoder's enablen.
- clear  input  1  synchronous active-high clear of all digits.
- mins  output  4  minutes digit, BCD.
- sec_tens  output  4  seconds-tens digit.
- sec_ones  output  4  seconds-ones digit.
- zero  output  1  high when all digits are 0.
- done  output  1  one-clk pulse when the count reaches 00:00 from a nonzero value in RUN.
- beep  output  1  end-of-cook tone enable; tied 0 unless TIMER_BEEP_EN.

Behaviour:
- Reset (rst=1 at a clk edge): mins, sec_tens and sec_ones become 0; zero=1; done=0; beep=0; state=IDLE.
- Reset initialises the edge registers to loadn_q=1 and pgt_q=0, so no spurious edge is seen after reset.
- Key event: loadn_q=1 and loadn=0, i.e. one event per keypress regardless of how long the key is held.
- Tick event: pgt_q=0 and pgt_1hz=1.
- Both events take effect 1 clk after detection; outputs are registered.
- States:
  - IDLE: digits are 0.
  - SET: at least one digit has been entered.
  - RUN: counting down.
  - PAUSE: enablen returned high while in RUN with a nonzero count.
- Key event with enablen=1 in IDLE, SET or PAUSE shifts the digits left:
  - mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= bcd_in.
  - The old mins value is discarded.
  - Next state is SET, except PAUSE stays PAUSE.
- Key events while enablen=0 are ignored.
- The encoder also suppresses them, but this block must not depend on that.
- enablen=0 in SET or PAUSE with zero=0 goes to RUN.
- enablen=0 in IDLE, or with zero=1, produces no state change.
- RUN, on a tick event, decrements the count:
  - If sec_ones>0, decrement sec_ones.
  - Else set sec_ones=SEC_ONES_WRAP, and if sec_tens>0 decrement sec_tens.
  - Else also set sec_tens=SEC_TENS_WRAP and decrement mins.
  - Entered sec_tens values 6..9 are legal: 0:99 counts 99 s, 0:99 -> 0:98 ... 0:90 -> 0:89.
- When the result is 0:00: done=1 for exactly one clk, state=IDLE, and further ticks are ignored.
- RUN with enablen=1 goes to PAUSE; digits are held.
- clear=1 zeroes the digits and goes to IDLE from any state.
  - clear has priority over key and tick events in the same cycle.
  - clear during a beep stops the beep.
- Tick and key events in the same cycle: the tick applies only in RUN and the key only when not in RUN, so they never both act.
- zero is combinational from the registered digits: (mins|sec_tens|sec_ones)==0.
- Non-BCD bcd_in (10..15) is shifted in unchanged; the encoder never produces such values.

Optional Feature:
- Macro: TIMER_BEEP_EN.
- Defined:
  - beep goes to 1 on the clk after done.
  - beep stays high for BEEP_TICKS tick events, then returns to 0.
  - A key event or clear ends the beep immediately.
  - A beep counter of width $clog2(BEEP_TICKS+1) is instantiated.
- Undefined: beep is constant 0 and no counter logic is present.

Decomposition:
- Shared package timer_pkg:
  - State enum: IDLE, SET, RUN, PAUSE, 2-bit encoding.
  - BCD digit typedef, logic [3:0].
  - Constants BCD_ZERO and BCD_NINE.
- Sub-module edge_detect:
  - One instance each for loadn (falling edge) and pgt_1hz (rising edge).
  - Reset value is a parameter.
  - Also reusable by the door/start-button logic.

Test Plan:
- Reset, then key events 1,3,0 with enablen=1 -> after each: 0:01, 0:13, 1:30; state=SET; zero=0.
- 1:30 loaded, enablen=0, 3 tick events -> 1:29, 1:28, 1:27; two more keys while running -> digits unchanged.
- 0:02 loaded, run, 2 ticks -> 0:01, then 0:00 with done high for 1 clk and zero=1; a 3rd tick -> no change, done stays 0.
- 1:00 running, 1 tick -> 0:59; enablen=1 then key 5 -> 0:59 stays PAUSE and shifts to 5:95; enablen=0 plus a tick -> 5:94.
- clear asserted in the same clk as a tick during RUN at 0:10 -> 0:00 and IDLE, no done pulse; rst mid-RUN -> all zero next clk.
- With TIMER_BEEP_EN and BEEP_TICKS=3:
  - 0:01, one tick -> beep high for 3 subsequent ticks, then low.
  - Repeat, then key during beep -> beep low next clk.
